// File: rtl/video_timing_gen_if.sv
// Video bus between the raster/pattern generator and the pixel-processing stage.
// The generator drives it through the master modport; the consumer uses slave.
interface video_timing_gen_if;
   logic        cen_i;
   logic [1:0]  pat_sel_i;
   logic [23:0] solid_rgb_i;
   logic [23:0] vid_rgb_o;
   logic [1:0]  vh_blank_o;
   logic [2:0]  dvh_sync_o;
   logic        frame_start_o;

   modport master (
      input  cen_i, pat_sel_i, solid_rgb_i,
      output vid_rgb_o, vh_blank_o, dvh_sync_o, frame_start_o
   );

   modport slave (
      output cen_i, pat_sel_i, solid_rgb_i,
      input  vid_rgb_o, vh_blank_o, dvh_sync_o, frame_start_o
   );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator with a built-in test-pattern source.
// Counters point at the pixel registered on the next enabled edge.
module video_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   video_timing_gen_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] HS_ON    = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_OFF   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] VS_ON    = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic [11:0] bar_px_q, bar_px_d;
   logic [2:0]  bar_idx_q, bar_idx_d;
   logic [1:0]  pat_q, pat_d;
   logic [23:0] rgb_q, rgb_d;
   logic [1:0]  blank_q, blank_d;
   logic [2:0]  sync_q, sync_d;
   logic        fs_q, fs_d;

   logic        line_end, frame_end, first_px;
   logic        hblank, vblank, active, hsync, vsync;
   logic [1:0]  pat_cur;
   logic [11:0] chk_x;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   assign line_end  = (h_cnt_q == H_LAST);
   assign frame_end = line_end && (v_cnt_q == V_LAST);
   assign first_px  = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
   // A new pattern takes effect from pixel (0,0) itself, never mid-frame.
   assign pat_cur   = first_px ? vif.pat_sel_i : pat_q;

   assign hblank = (h_cnt_q >= H_ACT);
   // Vblank edges land on the Hblank rising edge so frame start is detectable downstream.
   assign vblank = ((v_cnt_q == V_ACT_LAST) && hblank) ||
                   ((v_cnt_q >= V_ACT) && (v_cnt_q < V_LAST)) ||
                   ((v_cnt_q == V_LAST) && !hblank);
   assign active = !hblank && (v_cnt_q < V_ACT);
   assign hsync  = (h_cnt_q >= HS_ON) && (h_cnt_q < HS_OFF);
   assign vsync  = (v_cnt_q >= VS_ON) && (v_cnt_q < VS_OFF);
   assign chk_x  = h_cnt_q + {4'd0, frame_cnt_q};

   always_comb begin
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      frame_cnt_d = frame_cnt_q;
      bar_px_d    = bar_px_q;
      bar_idx_d   = bar_idx_q;
      pat_d       = pat_q;
      rgb_d       = rgb_q;
      blank_d     = blank_q;
      sync_d      = sync_q;
      fs_d        = 1'b0;
      if (vif.cen_i) begin
         h_cnt_d = line_end ? 12'd0 : h_cnt_q + 12'd1;
         if (line_end) v_cnt_d = frame_end ? 11'd0 : v_cnt_q + 11'd1;
         if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
         if (line_end) begin
            bar_px_d  = 12'd0;
            bar_idx_d = 3'd0;
         end else if (bar_px_q == BAR_LAST) begin
            bar_px_d  = 12'd0;
            bar_idx_d = bar_idx_q + 3'd1;
         end else begin
            bar_px_d  = bar_px_q + 12'd1;
         end
         pat_d = pat_cur;
         rgb_d = 24'h000000;
         if (active) begin
            case (pat_cur)
               2'd0:    rgb_d = bar_colour(bar_idx_q);
               2'd1:    rgb_d = {3{h_cnt_q[10:3]}};
               2'd2:    rgb_d = (chk_x[6] ^ v_cnt_q[6]) ? 24'h000000 : 24'hFFFFFF;
               default: rgb_d = vif.solid_rgb_i;
            endcase
         end
         blank_d = {vblank, hblank};
         sync_d  = {active, vsync ? VS_POL : ~VS_POL, hsync ? HS_POL : ~HS_POL};
         fs_d    = first_px;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         h_cnt_q     <= 12'd0;
         v_cnt_q     <= 11'd0;
         frame_cnt_q <= 8'd0;
         bar_px_q    <= 12'd0;
         bar_idx_q   <= 3'd0;
         pat_q       <= 2'd0;
         rgb_q       <= 24'h000000;
         blank_q     <= 2'b11;
         sync_q      <= {1'b0, ~VS_POL, ~HS_POL};
         fs_q        <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         bar_px_q    <= bar_px_d;
         bar_idx_q   <= bar_idx_d;
         pat_q       <= pat_d;
         rgb_q       <= rgb_d;
         blank_q     <= blank_d;
         sync_q      <= sync_d;
         fs_q        <= fs_d;
      end
   end

   assign vif.vid_rgb_o     = rgb_q;
   assign vif.vh_blank_o    = blank_q;
   assign vif.dvh_sync_o    = sync_q;
   assign vif.frame_start_o = fs_q;
endmodule
